// File: rtl/mod_arith_pkg.sv
// rtl/mod_arith_pkg.sv - shared types and helpers for the modular add/subtract sequencer
package mod_arith_pkg;

  localparam int unsigned MOD_WIDTH = 384;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    P1_ISSUE,
    P1_WAIT,
    P2_ISSUE,
    P2_WAIT,
    FINISH
  } state_t;

  // True when the pass-2 (corrected) value is the reduced result.
  function automatic logic use_corrected(logic op, logic s_msb, logic t_msb);
    return (op == OP_ADD) ? (s_msb | ~t_msb) : s_msb;
  endfunction

endpackage

// File: rtl/mod_addsub_ctrl.sv
// rtl/mod_addsub_ctrl.sv - two-pass modular add/subtract sequencer around a shared wide adder
// Optional: MODARITH_EARLY_EXIT_EN skips the correction pass for a non-borrowing subtract.
module mod_addsub_ctrl
  import mod_arith_pkg::*;
#(
  parameter int unsigned WIDTH = MOD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH-1:0] add_in_a,
  output logic [WIDTH-1:0] add_in_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done
);

  state_t             state_q, state_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH:0]     s_q, s_d;
  logic [WIDTH-1:0]   result_d;
  logic               sub_d;
  logic [WIDTH-1:0]   a_d, b_d;
  logic               early_exit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_ADD;
      m_q          <= '0;
      s_q          <= '0;
      result       <= '0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      m_q          <= m_d;
      s_q          <= s_d;
      result       <= result_d;
      add_subtract <= sub_d;
      add_in_a     <= a_d;
      add_in_b     <= b_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    m_d      = m_q;
    s_d      = s_q;
    result_d = result;
    sub_d    = add_subtract;
    a_d      = add_in_a;
    b_d      = add_in_b;
`ifdef MODARITH_EARLY_EXIT_EN
    early_exit = (op_q == OP_SUB) && !add_result[WIDTH];
`else
    early_exit = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = P1_ISSUE;
          op_d    = subtract;
          m_d     = in_m;
          sub_d   = subtract;
          a_d     = in_a;
          b_d     = in_b;
        end
      end
      P1_ISSUE: state_d = P1_WAIT;
      P1_WAIT: begin
        if (add_done) begin
          s_d = add_result;
          if (early_exit) begin
            state_d  = FINISH;
            result_d = add_result[WIDTH-1:0];
          end else begin
            // Add corrects by subtracting m; subtract corrects by adding m.
            state_d = P2_ISSUE;
            sub_d   = (op_q == OP_ADD);
            a_d     = add_result[WIDTH-1:0];
            b_d     = m_q;
          end
        end
      end
      P2_ISSUE: state_d = P2_WAIT;
      P2_WAIT: begin
        if (add_done) begin
          state_d  = FINISH;
          result_d = use_corrected(op_q, s_q[WIDTH], add_result[WIDTH])
                     ? add_result[WIDTH-1:0] : s_q[WIDTH-1:0];
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign add_start = (state_q == P1_ISSUE) || (state_q == P2_ISSUE);
  assign done      = (state_q == FINISH);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// tb/tb_mod_addsub_ctrl.sv - directed self-checking bench for mod_addsub_ctrl with a behavioural adder
module tb_mod_addsub_ctrl;
  import mod_arith_pkg::*;

  localparam int W = MOD_WIDTH;
`ifdef MODARITH_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         subtract;
  logic [W-1:0] in_a, in_b, in_m;
  logic [W-1:0] result;
  logic         done, busy;
  logic         add_start, add_subtract;
  logic [W-1:0] add_in_a, add_in_b;
  logic [W:0]   add_result;
  logic         add_done;

  int           lat = 3;
  int           cnt;
  logic         stub_done;
  logic         inj_done;
  int           ntests = 0;
  int           nfail  = 0;

  mod_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .result(result), .done(done), .busy(busy),
    .add_start(add_start), .add_subtract(add_subtract),
    .add_in_a(add_in_a), .add_in_b(add_in_b),
    .add_result(add_result), .add_done(add_done)
  );

  always #5 clk = ~clk;

  assign add_done = stub_done | inj_done;

  // Behavioural adder: result captured at add_start, done pulsed L cycles later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= 0;
      stub_done  <= 1'b0;
      add_result <= '0;
    end else begin
      stub_done <= 1'b0;
      if (add_start) begin
        add_result <= add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                   : ({1'b0, add_in_a} + {1'b0, add_in_b});
        if (lat <= 1) stub_done <= 1'b1;
        else cnt <= lat - 1;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) stub_done <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the first busy cycle; returns at the done cycle.
  task automatic wait_done(output int n, output int starts, output int drops);
    n = 1; starts = 0; drops = 0;
    while (n < 200) begin
      if (add_start) starts++;
      if (!busy) drops++;
      if (done) break;
      @(negedge clk);
      n++;
    end
    if (!done) n = -1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                       input logic sub, input logic hold,
                       output int n, output int starts, output int drops);
    @(negedge clk);
    in_a = a; in_b = b; in_m = m; subtract = sub; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    wait_done(n, starts, drops);
  endtask

  initial begin : main
    int n, st, dr, quiet;
    logic [W-1:0] big_m, big_a, big_r;

    reset = 1'b1; start = 1'b0; subtract = 1'b0; inj_done = 1'b0;
    in_a = '0; in_b = '0; in_m = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_start", add_start, 0);
    chk("rst_add_subtract", add_subtract, 0);
    chk("rst_add_in_a", add_in_a, 0);
    chk("rst_add_in_b", add_in_b, 0);
    reset = 1'b0;

    do_op(7, 9, 13, 1'b0, 1'b0, n, st, dr);
    chk("add_7_9_res", result, 3);
    chk("add_7_9_lat", n, 9);
    chk("add_7_9_starts", st, 2);
    chk("add_7_9_busy", dr, 0);

    do_op(5, 9, 13, 1'b1, 1'b0, n, st, dr);
    chk("sub_5_9_res", result, 9);
    chk("sub_5_9_lat", n, 9);

    do_op(9, 5, 13, 1'b1, 1'b0, n, st, dr);
    chk("sub_9_5_res", result, 4);
    chk("sub_9_5_lat", n, EARLY ? 5 : 9);
    chk("sub_9_5_starts", st, EARLY ? 1 : 2);

    do_op(6, 6, 13, 1'b1, 1'b0, n, st, dr);
    chk("sub_6_6_res", result, 0);
    chk("sub_6_6_lat", n, EARLY ? 5 : 9);

    do_op(6, 7, 13, 1'b0, 1'b0, n, st, dr);
    chk("add_eq_m_res", result, 0);

    big_m = '1;
    big_a = '1; big_a[0] = 1'b0;
    big_r = '1; big_r[1] = 1'b0;
    do_op(big_a, big_a, big_m, 1'b0, 1'b0, n, st, dr);
    chk("add_big_res", result, big_r);
    chk("add_big_lat", n, 9);

    lat = 1;
    do_op(7, 9, 13, 1'b0, 1'b0, n, st, dr);
    chk("l1_add_res", result, 3);
    chk("l1_add_lat", n, 5);
    lat = 3;

    // start held high across an operation
    do_op(7, 9, 13, 1'b0, 1'b1, n, st, dr);
    chk("hold_res", result, 3);
    chk("hold_lat", n, 9);
    chk("hold_starts", st, 2);
    chk("hold_busy", dr, 0);
    @(negedge clk);
    chk("hold_idle_busy", busy, 0);
    chk("hold_single_done", done, 0);
    in_a = 1; in_b = 2;
    @(negedge clk);
    chk("hold_reaccept", busy, 1);
    start = 1'b0;
    wait_done(n, st, dr);
    chk("hold2_res", result, 3);
    chk("hold2_lat", n, 9);

    // reset during the second adder pass
    @(negedge clk);
    in_a = 7; in_b = 9; in_m = 13; subtract = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_add_start", add_start, 0);
    chk("abort_add_in_a", add_in_a, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy || add_start) quiet++;
      @(negedge clk);
    end
    chk("abort_quiet", quiet, 0);
    chk("abort_result_hold", result, 0);

    do_op(1, 1, 13, 1'b0, 1'b0, n, st, dr);
    chk("post_abort_res", result, 2);
    chk("post_abort_lat", n, 9);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
